// File: rtl/pcm_i2s_tx.sv
// Mono PCM to I2S transmitter: sample FIFO, BCLK/LRCLK generation and a
// 32-bit frame serializer that sends each sample on both channels.
module pcm_i2s_tx #(
    parameter int CLK_DIV    = 32,
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_W     = $clog2(FIFO_DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [15:0]       pcm_in,
    input  logic              pcm_valid_in,
    input  logic              mute,
    output logic              i2s_bclk,
    output logic              i2s_lrclk,
    output logic              i2s_sdata,
    output logic [ADDR_W:0]   fifo_level,
    output logic              frame_start,
    output logic              overflow,
    output logic              underflow
);

    localparam int               DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [ADDR_W:0]  LEVEL_FULL = (ADDR_W + 1)'(FIFO_DEPTH);

    logic [DIV_W-1:0]  div_cnt;
    logic [4:0]        slot_cnt;
    logic [4:0]        slot_next;
    logic [31:0]       shift_reg;
    logic [31:0]       frame_word;
    logic [15:0]       fifo_mem [FIFO_DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              div_tc;
    logic              fall_evt;
    logic              fetch;
    logic              fifo_empty;
    logic              fifo_full;
    logic              do_pop;
    logic              do_push;
    logic              drop;

    always_comb begin
        div_tc     = (div_cnt == DIV_LAST);
        fall_evt   = div_tc && i2s_bclk;
        slot_next  = slot_cnt + 5'd1;
        fetch      = fall_evt && (slot_cnt == 5'd31);
        fifo_empty = (fifo_level == '0);
        fifo_full  = (fifo_level == LEVEL_FULL);
        do_pop     = fetch && !fifo_empty;
        // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
        do_push    = pcm_valid_in && (!fifo_full || do_pop);
        drop       = pcm_valid_in && fifo_full && !do_pop;
        frame_word = 32'h0;
        if (do_pop && !mute) begin
            frame_word = {fifo_mem[rd_ptr], fifo_mem[rd_ptr]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt  <= '0;
            i2s_bclk <= 1'b0;
        end else if (div_tc) begin
            div_cnt  <= '0;
            i2s_bclk <= ~i2s_bclk;
        end else begin
            div_cnt  <= div_cnt + DIV_W'(1);
        end
    end

    // The fetch event emits the previous frame's last bit before reloading, giving the one-BCLK MSB delay.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt  <= 5'd31;
            i2s_lrclk <= 1'b0;
            i2s_sdata <= 1'b0;
            shift_reg <= 32'h0;
        end else if (fall_evt) begin
            slot_cnt  <= slot_next;
            i2s_lrclk <= slot_next[4];
            i2s_sdata <= shift_reg[31];
            if (fetch) begin
                shift_reg <= frame_word;
            end else begin
                shift_reg <= {shift_reg[30:0], 1'b0};
            end
        end
    end

    // Storage needs no reset: an empty FIFO never exposes stale entries.
    always_ff @(posedge clk) begin
        if (do_push) begin
            fifo_mem[wr_ptr] <= pcm_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   fifo_level <= fifo_level + (ADDR_W + 1)'(1);
                2'b01:   fifo_level <= fifo_level - (ADDR_W + 1)'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_start <= 1'b0;
            underflow   <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            frame_start <= fetch;
            underflow   <= fetch && fifo_empty;
            overflow    <= drop;
        end
    end

endmodule

// File: tb/tb_pcm_i2s_tx.sv
// Bench for pcm_i2s_tx: constant checkpoint table, corner-case sequences and
// randomized traffic compared every cycle against a frame-level reference model.
module tb_pcm_i2s_tx;

    localparam int CLK_DIV    = 4;
    localparam int FIFO_DEPTH = 16;
    localparam int ADDR_W     = 4;
    localparam int FRAME      = 64 * CLK_DIV;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [15:0]       pcm_in = 16'h0;
    logic              pcm_valid_in = 1'b0;
    logic              mute = 1'b0;
    logic              i2s_bclk;
    logic              i2s_lrclk;
    logic              i2s_sdata;
    logic [ADDR_W:0]   fifo_level;
    logic              frame_start;
    logic              overflow;
    logic              underflow;

    pcm_i2s_tx #(
        .CLK_DIV    (CLK_DIV),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pcm_in       (pcm_in),
        .pcm_valid_in (pcm_valid_in),
        .mute         (mute),
        .i2s_bclk     (i2s_bclk),
        .i2s_lrclk    (i2s_lrclk),
        .i2s_sdata    (i2s_sdata),
        .fifo_level   (fifo_level),
        .frame_start  (frame_start),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    int          t;
    logic [15:0] model_q [$];
    logic [31:0] cur_word;
    logic [31:0] prev_word;
    logic        e_bclk, e_lrclk, e_sdata, e_fs, e_ov, e_uf;
    int          e_level;

    typedef struct {
        int          scen;
        int          cyc;
        logic        valid;
        logic [15:0] data;
        logic        e_bclk;
        logic        e_lrclk;
        logic        e_sdata;
        logic        e_fs;
        logic        e_uf;
        int          e_level;
    } vec_t;

    vec_t tbl [18];

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, t, act, exp);
        end
    endtask

    task automatic model_reset();
        t = 0;
        model_q.delete();
        cur_word  = 32'h0;
        prev_word = 32'h0;
        e_bclk = 0; e_lrclk = 0; e_sdata = 0; e_fs = 0; e_ov = 0; e_uf = 0;
        e_level = 0;
    endtask

    // Frame-level model: cycle t since reset decides BCLK phase and slot; sdata is picked from the frame word.
    task automatic model_edge(input logic v, input logic [15:0] d, input logic m);
        int          s;
        int          size;
        bit          fetch_now;
        bit          popped;
        logic [15:0] smp;
        t++;
        e_bclk    = ((t / CLK_DIV) % 2) == 1;
        s         = -1;
        fetch_now = 0;
        if (t % (2 * CLK_DIV) == 0) begin
            s         = (t / (2 * CLK_DIV) - 1) % 32;
            e_lrclk   = (s >= 16);
            fetch_now = (s == 0);
        end
        size   = model_q.size();
        popped = fetch_now && size > 0;
        e_fs   = fetch_now;
        e_uf   = fetch_now && size == 0;
        e_ov   = v && size == FIFO_DEPTH && !popped;
        if (fetch_now) begin
            prev_word = cur_word;
            cur_word  = 32'h0;
            if (popped) begin
                smp = model_q.pop_front();
                if (!m) cur_word = {smp, smp};
            end
        end
        if (v && (size < FIFO_DEPTH || popped)) model_q.push_back(d);
        e_level = model_q.size();
        if (s == 0)      e_sdata = prev_word[0];
        else if (s > 0)  e_sdata = cur_word[32 - s];
    endtask

    task automatic apply_stimulus(input logic v, input logic [15:0] d, input logic m);
        pcm_valid_in = v;
        pcm_in       = d;
        mute         = m;
        @(posedge clk);
        #1;
        model_edge(v, d, m);
        check_output("bclk", 32'(i2s_bclk), 32'(e_bclk));
        check_output("lrclk", 32'(i2s_lrclk), 32'(e_lrclk));
        check_output("sdata", 32'(i2s_sdata), 32'(e_sdata));
        check_output("frame_start", 32'(frame_start), 32'(e_fs));
        check_output("overflow", 32'(overflow), 32'(e_ov));
        check_output("underflow", 32'(underflow), 32'(e_uf));
        check_output("fifo_level", 32'(fifo_level), 32'(e_level));
    endtask

    task automatic run_to(input int cyc, input logic m);
        while (t < cyc) apply_stimulus(1'b0, 16'h0, m);
    endtask

    // Reset asserted mid-cycle must clear the outputs without waiting for a clock edge.
    task automatic apply_reset();
        #3;
        rst_n = 1'b0;
        pcm_valid_in = 1'b0;
        mute = 1'b0;
        #2;
        check_output("rst_bclk", 32'(i2s_bclk), 32'h0);
        check_output("rst_lrclk", 32'(i2s_lrclk), 32'h0);
        check_output("rst_sdata", 32'(i2s_sdata), 32'h0);
        check_output("rst_level", 32'(fifo_level), 32'h0);
        check_output("rst_frame_start", 32'(frame_start), 32'h0);
        check_output("rst_overflow", 32'(overflow), 32'h0);
        check_output("rst_underflow", 32'(underflow), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int cur_scen;
        int p;
        model_reset();

        tbl[0]  = '{1,   3, 1'b0, 16'h0,    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        tbl[1]  = '{1,   4, 1'b0, 16'h0,    1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        tbl[2]  = '{1,   7, 1'b0, 16'h0,    1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        tbl[3]  = '{1,   8, 1'b0, 16'h0,    1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0};
        tbl[4]  = '{1,   9, 1'b0, 16'h0,    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        tbl[5]  = '{1, 135, 1'b0, 16'h0,    1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        tbl[6]  = '{1, 136, 1'b0, 16'h0,    1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0};
        tbl[7]  = '{1, 264, 1'b0, 16'h0,    1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0};
        tbl[8]  = '{2,   2, 1'b1, 16'hA5C3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        tbl[9]  = '{2,   8, 1'b0, 16'h0,    1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0};
        tbl[10] = '{2,  16, 1'b0, 16'h0,    1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0};
        tbl[11] = '{2,  20, 1'b0, 16'h0,    1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0};
        tbl[12] = '{2,  24, 1'b0, 16'h0,    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        tbl[13] = '{2, 128, 1'b0, 16'h0,    1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0};
        tbl[14] = '{2, 136, 1'b0, 16'h0,    1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0};
        tbl[15] = '{2, 144, 1'b0, 16'h0,    1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0};
        tbl[16] = '{2, 152, 1'b0, 16'h0,    1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0};
        tbl[17] = '{2, 264, 1'b0, 16'h0,    1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 0};

        #1;
        cur_scen = 0;
        for (int i = 0; i < 18; i++) begin
            if (tbl[i].scen != cur_scen) begin
                apply_reset();
                cur_scen = tbl[i].scen;
            end
            run_to(tbl[i].cyc - 1, 1'b0);
            apply_stimulus(tbl[i].valid, tbl[i].data, 1'b0);
            check_output("tbl_bclk", 32'(i2s_bclk), 32'(tbl[i].e_bclk));
            check_output("tbl_lrclk", 32'(i2s_lrclk), 32'(tbl[i].e_lrclk));
            check_output("tbl_sdata", 32'(i2s_sdata), 32'(tbl[i].e_sdata));
            check_output("tbl_frame_start", 32'(frame_start), 32'(tbl[i].e_fs));
            check_output("tbl_underflow", 32'(underflow), 32'(tbl[i].e_uf));
            check_output("tbl_level", 32'(fifo_level), 32'(tbl[i].e_level));
        end

        // Overflow on the 17th push, then a full FIFO pushed on the fetch cycle.
        apply_reset();
        run_to(9, 1'b0);
        for (int i = 0; i < 17; i++) begin
            apply_stimulus(1'b1, (i == 0) ? 16'hC001 : 16'(16'h0010 + i), 1'b0);
            if (i == 15) check_output("full_level", 32'(fifo_level), 32'd16);
            if (i == 16) begin
                check_output("ovf_pulse", 32'(overflow), 32'h1);
                check_output("ovf_level", 32'(fifo_level), 32'd16);
            end
        end
        apply_stimulus(1'b0, 16'h0, 1'b0);
        check_output("ovf_one_cycle", 32'(overflow), 32'h0);
        run_to(FRAME + 7, 1'b0);
        apply_stimulus(1'b1, 16'hBEEF, 1'b0);
        check_output("full_pushpop_fs", 32'(frame_start), 32'h1);
        check_output("full_pushpop_level", 32'(fifo_level), 32'd16);
        check_output("full_pushpop_ovf", 32'(overflow), 32'h0);
        run_to(FRAME + 16, 1'b0);
        check_output("oldest_msb", 32'(i2s_sdata), 32'h1);
        run_to(FRAME + 24, 1'b0);
        check_output("oldest_bit14", 32'(i2s_sdata), 32'h1);
        run_to(3 * FRAME, 1'b0);

        // Muted frames still consume samples.
        apply_reset();
        for (int i = 0; i < 4; i++) apply_stimulus(1'b1, 16'h7FFF, 1'b1);
        for (int m = 0; m < 5; m++) begin
            run_to(8 + FRAME * m - 1, 1'b1);
            apply_stimulus(1'b0, 16'h0, 1'b1);
            check_output("mute_level", 32'(fifo_level), (m < 4) ? 32'(3 - m) : 32'h0);
            check_output("mute_underflow", 32'(underflow), (m == 4) ? 32'h1 : 32'h0);
        end

        // Reset in slot 10 with five samples queued, then fetch-boundary latency.
        apply_reset();
        for (int i = 0; i < 6; i++) apply_stimulus(1'b1, 16'hFFFF, 1'b0);
        run_to(93, 1'b0);
        check_output("pre_rst_level", 32'(fifo_level), 32'd5);
        check_output("pre_rst_bclk", 32'(i2s_bclk), 32'h1);
        check_output("pre_rst_sdata", 32'(i2s_sdata), 32'h1);
        apply_reset();
        run_to(3, 1'b0);
        check_output("restart_bclk_lo", 32'(i2s_bclk), 32'h0);
        run_to(6, 1'b0);
        apply_stimulus(1'b1, 16'h1234, 1'b0);
        apply_stimulus(1'b0, 16'h0, 1'b0);
        check_output("late_push_fs", 32'(frame_start), 32'h1);
        check_output("late_push_uf", 32'(underflow), 32'h0);
        check_output("late_push_level", 32'(fifo_level), 32'h0);
        run_to(FRAME + 7, 1'b0);
        apply_stimulus(1'b1, 16'h5678, 1'b0);
        check_output("nobypass_uf", 32'(underflow), 32'h1);
        check_output("nobypass_level", 32'(fifo_level), 32'h1);
        run_to(2 * FRAME + 16, 1'b0);

        // Random traffic alternating bursty and sparse phases, with random mute.
        apply_reset();
        for (int i = 0; i < 3000; i++) begin
            p = (((i / 600) % 2) == 0) ? 12 : 1;
            apply_stimulus(($urandom_range(0, 99) < p), 16'($urandom), ($urandom_range(0, 7) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pcm_i2s_tx.md
Name: pcm_i2s_tx

Overview:
Output stage fed by the audio source selector. It takes the selected PCM sample stream (pcm_out/pcm_valid_out) and buffers it in a small FIFO. It then serializes each sample as a mono I2S frame, with the same sample on left and right, to the board DAC/codec. It generates BCLK and LRCLK from the system clock and handles overflow, underflow and mute.

Parameters:
CLK_DIV, 32, system clocks per BCLK half-period (>=2); BCLK = f_clk/(2*CLK_DIV)
FIFO_DEPTH, 16, sample FIFO depth; power of two, >=2
ADDR_W, $clog2(FIFO_DEPTH), FIFO pointer width (derived, not overridden)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
pcm_in  in  16  signed PCM sample from selector
pcm_valid_in  in  1  sample strobe; one sample per high cycle
mute  in  1  force zero samples while high
i2s_bclk  out  1  bit clock
i2s_lrclk  out  1  word select; 0 = left, 1 = right
i2s_sdata  out  1  serial data, changes on BCLK falling edge
fifo_level  out  ADDR_W+1  current FIFO occupancy, 0..FIFO_DEPTH
frame_start  out  1  1-cycle pulse at each frame fetch
overflow  out  1  1-cycle pulse when a sample is dropped (FIFO full)
underflow  out  1  1-cycle pulse when a fetch finds the FIFO empty

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: bclk=0, lrclk=0, sdata=0, frame_start=0, overflow=0, underflow=0, fifo_level=0.
- Reset internals: divider=0, slot counter=31, shift register=0, FIFO empty.
- Reset mid-operation: all state clears immediately, including FIFO contents. No partial frame resumes.
- Divider: counts 0..CLK_DIV-1. At terminal count bclk toggles.
  - Rising edge: clk where bclk goes 0->1.
  - Falling event: clk where bclk goes 1->0. First falling event is 2*CLK_DIV clks after reset release.
- Slot counter s (5 bits): increments mod 32 on each falling event. Frame = 32 BCLK.
- lrclk is registered on each falling event to the new s[4]. Low during slots 0..15, high during 16..31.
- Fetch: on the falling event entering s=0, frame_start=1 for that clk.
  - FIFO non-empty: pop one sample S. 32-bit shift register loads {S,S}, or 0 if mute=1 (pop still happens).
  - FIFO empty: shift register loads 0 and underflow pulses.
- Serial data (I2S standard, one-BCLK MSB delay): on each falling event, sdata takes the shift register MSB and the register shifts left by 1.
  - Left MSB appears in slot 1, left LSB in slot 16.
  - Right MSB appears in slot 17, right LSB in slot 0 of the next frame.
  - sdata is registered and stable across each rising edge.
- FIFO write: pcm_valid_in=1 and not full -> push pcm_in. Full -> sample dropped and overflow pulses. Samples are not sign- or width-modified.
- Simultaneous push and pop in the same clk:
  - Full: push accepted, level unchanged, no overflow.
  - Empty: no bypass; underflow pulses, push accepted, level becomes 1.
- fifo_level is registered and reflects push/pop of the previous clk. Pointers wrap mod FIFO_DEPTH.
- mute is sampled only at fetch. A mid-frame change takes effect next frame.
- Latency: a sample pushed into an empty FIFO at or before the fetch clk's preceding cycle is sent in that frame. Otherwise it is sent in the next frame.

Test Plan (CLK_DIV=4, FIFO_DEPTH=16; BCLK period 8 clk, frame 256 clk):
1. Release reset with no input -> bclk first rises at clk 4 and falls at clk 8. At clk 8: frame_start=1, underflow=1, lrclk=0. sdata stays 0 for the whole frame. fifo_level=0.
2. Push 16'hA5C3 at clk 2 -> pops at clk 8, fifo_level back to 0. sdata slots 1..16 = 1010010111000011, slots 17..31 then next slot 0 repeat the same word. lrclk rises entering slot 16.
3. Push 17 back-to-back samples starting at clk 10 (no fetch until clk 264) -> fifo_level reaches 16. overflow pulses on the 17th push and that sample never appears on sdata.
4. FIFO holds four 16'h7FFF samples, mute=1 -> sdata all 0 for four frames. fifo_level goes 4->3->2->1->0 at successive frame_starts, no underflow until the fifth.
5. FIFO full (16), pcm_valid_in=1 on the fetch clk -> fifo_level stays 16, overflow=0, the popped sample is the oldest entry.
6. Drop rst_n at slot 10 of a frame with fifo_level=5 -> same clk: bclk, lrclk and sdata are 0 and fifo_level=0. After release, timing restarts exactly as scenario 1.
